// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU operation codes,
// RV32 opcode/funct field values, FSM state type and the decode bundle.
package alu_pkg;

  // ALU operation codes understood by the external ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  // RV32 major opcodes handled here
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Result of decoding one instruction word
  typedef struct packed {
    logic [3:0]  alu_op;
    logic        op2_rs2;    // 1: op2 comes from rs2_data, 0: from imm
    logic [31:0] imm;
    logic        is_branch;
    logic        branch_ne;  // 1: BNE, 0: BEQ
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/alu_decoder.sv
// Purely combinational RV32 decode: ALU op, operand-2 source, immediate,
// branch kind and illegal flag.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] shamt;
  logic        unused_fields;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign shamt  = {27'b0, instr_i[24:20]};

  // Register specifiers are not needed; operands arrive on the data ports.
  assign unused_fields = ^{instr_i[19:15], instr_i[11:7]};

  // Map opcode/funct fields onto an ALU operation; anything unlisted is illegal
  always_comb begin
    dec_o         = '0;
    dec_o.illegal = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec_o.op2_rs2 = 1'b1;
        dec_o.illegal = 1'b0;
        unique case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_BASE)     dec_o.alu_op = ALU_ADD;
            else if (funct7 == F7_ALT) dec_o.alu_op = ALU_SUB;
            else                       dec_o.illegal = 1'b1;
          end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE)     dec_o.alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_o.alu_op = ALU_SRA;
            else                       dec_o.illegal = 1'b1;
          end
          F3_SLL:  dec_o.alu_op = ALU_SLL;
          F3_SLT:  dec_o.alu_op = ALU_SLT;
          F3_XOR:  dec_o.alu_op = ALU_XOR;
          F3_OR:   dec_o.alu_op = ALU_OR;
          F3_AND:  dec_o.alu_op = ALU_AND;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_o.imm     = imm_i;
        dec_o.illegal = 1'b0;
        unique case (funct3)
          F3_ADD_SUB: dec_o.alu_op = ALU_ADD;
          F3_SLT:     dec_o.alu_op = ALU_SLT;
          F3_XOR:     dec_o.alu_op = ALU_XOR;
          F3_OR:      dec_o.alu_op = ALU_OR;
          F3_AND:     dec_o.alu_op = ALU_AND;
          F3_SLL: begin
            dec_o.imm     = shamt;
            dec_o.alu_op  = ALU_SLL;
            dec_o.illegal = (funct7 != F7_BASE);
          end
          F3_SRL_SRA: begin
            dec_o.imm    = shamt;
            dec_o.alu_op = instr_i[30] ? ALU_SRA : ALU_SRL;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec_o.op2_rs2   = 1'b1;
        dec_o.alu_op    = ALU_SUB;
        dec_o.is_branch = 1'b1;
        if (funct3 == F3_BEQ) begin
          dec_o.illegal = 1'b0;
        end else if (funct3 == F3_BNE) begin
          dec_o.branch_ne = 1'b1;
          dec_o.illegal   = 1'b0;
        end
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one RV32 ALU/branch instruction at a time to an external ALU and
// returns the result over a valid/ready response channel.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | instr_ready=1, waiting for an instruction
// EXEC   | latched op/operands driven to the ALU; result captured at exit
// RESP   | resp_valid=1 with a stable payload until resp_ready
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_taken,
  output logic        resp_illegal
);

  dec_t        dec;
  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        br_q, br_d;
  logic        ne_q, ne_d;
  logic [31:0] data_q, data_d;
  logic        taken_q, taken_d;
  logic        illegal_q, illegal_d;

  alu_decoder u_dec (
    .instr_i (instr),
    .dec_o   (dec)
  );

  // Next state and next payload/operand values
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    br_d      = br_q;
    ne_d      = ne_q;
    data_d    = data_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d      = dec.illegal ? ALU_AND : dec.alu_op;
          op1_d     = rs1_data;
          op2_d     = dec.op2_rs2 ? rs2_data : dec.imm;
          br_d      = dec.is_branch;
          ne_d      = dec.branch_ne;
          illegal_d = dec.illegal;
          data_d    = '0;
          taken_d   = 1'b0;
          // Illegal instructions skip the ALU entirely
          state_d   = dec.illegal ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        data_d  = br_q ? '0 : alu_result;
        taken_d = br_q & (alu_zero ^ ne_q);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched values, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= ALU_AND;
      op1_q     <= '0;
      op2_q     <= '0;
      br_q      <= 1'b0;
      ne_q      <= 1'b0;
      data_q    <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      br_q      <= br_d;
      ne_q      <= ne_d;
      data_q    <= data_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign alu_op       = (state_q == S_EXEC) ? op_q  : ALU_AND;
  assign alu_op1      = (state_q == S_EXEC) ? op1_q : '0;
  assign alu_op2      = (state_q == S_EXEC) ? op2_q : '0;
  assign resp_data    = data_q;
  assign resp_taken   = taken_q;
  assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written
// reset sequences and randomized instructions against a mnemonic-level model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_taken;
  logic        resp_illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] op2;
    logic [31:0] data;
    logic        taken;
    logic        illegal;
    int          lat;
  } vec_t;

  typedef enum {M_ILL, M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT,
                M_SLL, M_SRL, M_SRA, M_BEQ, M_BNE} mn_t;

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .alu_op       (alu_op),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_taken   (resp_taken),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  // External ALU stand-in
  function automatic logic [31:0] alu_fn(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0101: return a ^ b;
      4'b1000: return a >> b[4:0];
      4'b1001: return a << b[4:0];
      4'b1010: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_op, alu_op1, alu_op2);
    alu_zero   = (alu_result == 32'd0);
  end

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_b(logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
  endfunction

  // Reference: identify the mnemonic, then compute its architectural result
  function automatic vec_t ref_model(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    vec_t        r;
    mn_t         m;
    logic [31:0] o2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    m  = M_ILL;
    o2 = b;
    if (ins[6:0] == 7'b0110011) begin
      case (f3)
        3'd0: if (f7 == 7'h00) m = M_ADD; else if (f7 == 7'h20) m = M_SUB;
        3'd1: m = M_SLL;
        3'd2: m = M_SLT;
        3'd4: m = M_XOR;
        3'd5: if (f7 == 7'h00) m = M_SRL; else if (f7 == 7'h20) m = M_SRA;
        3'd6: m = M_OR;
        3'd7: m = M_AND;
        default: m = M_ILL;
      endcase
    end else if (ins[6:0] == 7'b0010011) begin
      o2 = {{20{ins[31]}}, ins[31:20]};
      case (f3)
        3'd0: m = M_ADD;
        3'd2: m = M_SLT;
        3'd4: m = M_XOR;
        3'd6: m = M_OR;
        3'd7: m = M_AND;
        3'd1: begin o2 = 32'(ins[24:20]); if (f7 == 7'h00) m = M_SLL; end
        3'd5: begin o2 = 32'(ins[24:20]); if (ins[30]) m = M_SRA; else m = M_SRL; end
        default: m = M_ILL;
      endcase
    end else if (ins[6:0] == 7'b1100011) begin
      if (f3 == 3'd0) m = M_BEQ;
      else if (f3 == 3'd1) m = M_BNE;
    end
    r.instr   = ins;
    r.rs1     = a;
    r.rs2     = b;
    r.op2     = o2;
    r.illegal = (m == M_ILL);
    r.lat     = r.illegal ? 1 : 2;
    r.taken   = 1'b0;
    r.data    = 32'd0;
    r.op      = 4'b0000;
    case (m)
      M_ADD: begin r.op = 4'b0010; r.data = a + o2; end
      M_SUB: begin r.op = 4'b0110; r.data = a - o2; end
      M_AND: begin r.op = 4'b0000; r.data = a & o2; end
      M_OR:  begin r.op = 4'b0001; r.data = a | o2; end
      M_XOR: begin r.op = 4'b0101; r.data = a ^ o2; end
      M_SLT: begin r.op = 4'b0100; r.data = ($signed(a) < $signed(o2)) ? 32'd1 : 32'd0; end
      M_SLL: begin r.op = 4'b1001; r.data = a << o2[4:0]; end
      M_SRL: begin r.op = 4'b1000; r.data = a >> o2[4:0]; end
      M_SRA: begin r.op = 4'b1010; r.data = $unsigned($signed(a) >>> o2[4:0]); end
      M_BEQ: begin r.op = 4'b0110; r.taken = (a == b); end
      M_BNE: begin r.op = 4'b0110; r.taken = (a != b); end
      default: r.op = 4'b0000;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one instruction, follow it through EXEC/RESP, hold the response
  // for 'hold' cycles before accepting it.
  task automatic run_txn(input vec_t v, input int hold);
    int cnt;
    bit seen;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = v.instr;
    rs1_data    = v.rs1;
    rs2_data    = v.rs2;
    chk("ready_in_idle", 32'(instr_ready), 32'd1);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 8) begin
      @(negedge clk);
      instr_valid = 1'b0;
      cnt++;
      if (resp_valid) seen = 1'b1;
      else if (cnt == 1 && !v.illegal) begin
        chk("exec_alu_op", 32'(alu_op), 32'(v.op));
        chk("exec_alu_op1", alu_op1, v.rs1);
        chk("exec_alu_op2", alu_op2, v.op2);
      end
      if (v.illegal) chk("illegal_alu_op_idle", 32'(alu_op), 32'd0);
    end
    chk("resp_latency", 32'(cnt), 32'(v.lat));
    if (!seen) return;
    for (int h = 0; h <= hold; h++) begin
      resp_ready = (h == hold);
      chk("resp_data", resp_data, v.data);
      chk("resp_taken", 32'(resp_taken), 32'(v.taken));
      chk("resp_illegal", 32'(resp_illegal), 32'(v.illegal));
      chk("resp_valid_hold", 32'(resp_valid), 32'd1);
      chk("ready_in_resp", 32'(instr_ready), 32'd0);
      chk("alu_op_in_resp", 32'(alu_op), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk("resp_valid_after_ack", 32'(resp_valid), 32'd0);
    chk("ready_after_ack", 32'(instr_ready), 32'd1);
  endtask

  vec_t tbl[13];

  function automatic vec_t mk(logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                              logic [3:0] op, logic [31:0] o2, logic [31:0] d,
                              logic tk, logic il);
    vec_t r;
    r.instr = ins; r.rs1 = a; r.rs2 = b; r.op = op; r.op2 = o2;
    r.data = d; r.taken = tk; r.illegal = il; r.lat = il ? 1 : 2;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    rs1_data    = '0;
    rs2_data    = '0;
    resp_ready  = 1'b0;

    tbl[0]  = mk(enc_r(7'h00, 3'd0), 32'd5, 32'd7, 4'b0010, 32'd7, 32'd12, 1'b0, 1'b0);
    tbl[1]  = mk(enc_i(12'h404, 3'd5), 32'h8000_0000, 32'd0, 4'b1010, 32'd4, 32'hF800_0000, 1'b0, 1'b0);
    tbl[2]  = mk(enc_b(3'd0), 32'd9, 32'd9, 4'b0110, 32'd9, 32'd0, 1'b1, 1'b0);
    tbl[3]  = mk(enc_b(3'd1), 32'd9, 32'd9, 4'b0110, 32'd9, 32'd0, 1'b0, 1'b0);
    tbl[4]  = mk(32'h0000_0003, 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);
    tbl[5]  = mk(enc_r(7'h20, 3'd0), 32'd3, 32'd10, 4'b0110, 32'd10, 32'hFFFF_FFF9, 1'b0, 1'b0);
    tbl[6]  = mk(enc_i(12'hFFF, 3'd2), 32'hFFFF_FFFE, 32'd0, 4'b0100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    tbl[7]  = mk(enc_i(12'h401, 3'd1), 32'd1, 32'd0, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);
    tbl[8]  = mk(enc_b(3'd4), 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);
    tbl[9]  = mk(enc_i(12'h0F0, 3'd7), 32'h1234_5678, 32'd0, 4'b0000, 32'h0000_00F0, 32'h0000_0070, 1'b0, 1'b0);
    tbl[10] = mk(enc_r(7'h00, 3'd5), 32'h8000_0000, 32'd4, 4'b1000, 32'd4, 32'h0800_0000, 1'b0, 1'b0);
    tbl[11] = mk(enc_i(12'h800, 3'd4), 32'h0000_FFFF, 32'd0, 4'b0101, 32'hFFFF_F800, 32'hFFFF_07FF, 1'b0, 1'b0);
    tbl[12] = mk(enc_r(7'h00, 3'd3), 32'd1, 32'd2, 4'b0000, 32'd0, 32'd0, 1'b0, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_taken", 32'(resp_taken), 32'd0);
    chk("rst_resp_illegal", 32'(resp_illegal), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    rst = 1'b1;

    // Directed vectors; the first one also holds resp_ready low for 5 cycles
    for (int i = 0; i < 13; i++) run_txn(tbl[i], (i == 0) ? 5 : i % 3);

    // Reset while in EXEC abandons the instruction
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = enc_r(7'h00, 3'd0);
    rs1_data    = 32'd20;
    rs2_data    = 32'd22;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("pre_rst_exec_alu_op", 32'(alu_op), 32'b0010);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_exec_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_exec_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_exec_alu_op", 32'(alu_op), 32'd0);
    chk("rst_exec_alu_op1", alu_op1, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("abandoned_no_resp", 32'(resp_valid), 32'd0);

    // Reset while in RESP drops the response
    instr_valid = 1'b1;
    instr       = 32'h0000_0003;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("pre_rst_resp_valid", 32'(resp_valid), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_illegal_clr", 32'(resp_illegal), 32'd0);
    chk("rst_resp_instr_ready", 32'(instr_ready), 32'd1);
    rst = 1'b1;

    // Randomized instructions against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] imm;
      int          kind;
      kind = $urandom_range(0, 3);
      f3   = 3'($urandom_range(0, 7));
      imm  = 12'($urandom);
      case (kind)
        0: begin
          if (f3 == 3'd0 || f3 == 3'd5) begin
            case ($urandom_range(0, 2))
              0: f7 = 7'h00;
              1: f7 = 7'h20;
              default: f7 = 7'($urandom);
            endcase
          end else f7 = 7'h00;
          ins = enc_r(f7, f3);
        end
        1: begin
          if (f3 == 3'd1 && $urandom_range(0, 3) != 0) imm[11:5] = 7'h00;
          if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
          ins = enc_i(imm, f3);
        end
        2: ins = enc_b(f3);
        default: begin
          ins = $urandom;
          if (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011 || ins[6:0] == 7'b1100011)
            ins[6:0] = 7'b0000011;
        end
      endcase
      if ($urandom_range(0, 3) == 0)
        run_txn(ref_model(ins, 32'd77, 32'd77), $urandom_range(0, 2));
      else
        run_txn(ref_model(ins, $urandom, $urandom), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-low (rst=0 at a rising edge resets).
REQ-003 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1): instruction handshake; transfer when both are 1 at a rising edge.
REQ-004 SHALL have port instr, input, 32, RV32 instruction word.
REQ-005 SHALL have ports rs1_data and rs2_data, input, 32 each: source operands, sampled with instr.
REQ-006 SHALL have port alu_op, output, 4, ALU operation code to the external ALU.
REQ-007 SHALL have ports alu_op1 and alu_op2, output, 32 each: ALU operands.
REQ-008 SHALL have ports alu_result (input, 32) and alu_zero (input, 1), returned combinationally by the ALU.
REQ-009 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-010 SHALL have ports resp_data (output, 32), resp_taken (output, 1) and resp_illegal (output, 1): response payload.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP; all outputs registered or decoded from state only.
REQ-012 SHALL assert instr_ready=1 only in IDLE.
REQ-013 SHALL, on accept in IDLE, latch the instr decode, rs1_data and the selected op2; next state EXEC if legal, RESP if illegal.
REQ-014 SHALL in EXEC drive alu_op/alu_op1/alu_op2 from latched values for exactly one cycle, capture alu_result and alu_zero at that edge, then go to RESP.
REQ-015 SHALL outside EXEC drive alu_op=4'b0000, alu_op1=0, alu_op2=0.
REQ-016 SHALL in RESP hold resp_valid=1 with stable payload until resp_ready=1, then go to IDLE; no accept in the same cycle.
REQ-017 Latency: legal op, resp_valid rises 2 cycles after the accept edge; illegal op, 1 cycle; throughput at most 1 instruction per 3 cycles.
REQ-018 ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0100, XOR 0101, SRL 1000, SLL 1001, SRA 1010.
REQ-019 Opcode 0110011 (R-type), op2=rs2_data, decode by funct3/funct7:
- 000/0000000 ADD; 000/0100000 SUB.
- 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL.
- 101/0000000 SRL; 101/0100000 SRA.
REQ-020 Opcode 0010011 (I-type), op2=sign-extended instr[31:20], same funct3 map:
- ADDI, ANDI, ORI, XORI, SLTI.
- Shifts use op2={27'b0,instr[24:20]}; SLLI requires instr[31:25]=0; SRLI/SRAI select by instr[30].
REQ-021 Opcode 1100011 (branch), op2=rs2_data, alu_op=SUB:
- funct3 000 BEQ, resp_taken=alu_zero.
- funct3 001 BNE, resp_taken=!alu_zero.
- resp_data=0.
REQ-022 For every other opcode/funct combination: resp_illegal=1, resp_data=0, resp_taken=0, and no EXEC cycle occurs.
REQ-023 For legal non-branch ops: resp_data=captured alu_result, resp_taken=0, resp_illegal=0.

Reset
REQ-024 On rst=0 at a rising edge: state=IDLE; resp_valid, resp_taken and resp_illegal = 0; resp_data=0; alu_op=0000; alu_op1=0; alu_op2=0; latched operands cleared.
REQ-025 Reset in EXEC or RESP SHALL abandon the in-flight instruction with no response; instr_ready=1 in the first cycle after release.

Structure
REQ-026 Shared package alu_pkg SHALL hold the ALU op-code constants, the opcode/funct constants and the FSM state typedef.
REQ-027 Combinational decode (instr to alu_op, op2 select, immediate, branch kind, illegal) SHALL be one sub-module, alu_decoder; the ALU is instantiated outside this block.

Verification
REQ-028 R-type ADD, rs1=5, rs2=7 -> during EXEC alu_op=0010, op1=5, op2=7; resp_data=12, resp_valid 2 cycles after accept.
REQ-029 SRAI shamt=4, rs1=0x80000000 -> alu_op=1010, alu_op2=4; resp_data=0xF8000000.
REQ-030 BEQ rs1=rs2=9 -> alu_op=0110, resp_taken=1, resp_data=0; BNE with the same operands -> resp_taken=0.
REQ-031 Opcode 0000011 -> resp_illegal=1, resp_valid 1 cycle after accept, alu_op remains 0000 throughout.
REQ-032 resp_ready held 0 for 5 cycles in RESP -> payload stable and instr_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-033 rst=0 during EXEC -> next cycle resp_valid=0, instr_ready=1, alu_op=0000.
